// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, one write port,
// same-cycle write-to-read forwarding and a busy-bit scoreboard for hazard detection.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    RS1,
  input  logic [AW-1:0]    RS2,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             a_busy,
  output logic             b_busy,
  input  logic             w,
  input  logic [AW-1:0]    RD,
  input  logic [WIDTH-1:0] C,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_rd,
  output logic [AW:0]      busy_cnt,
  output logic             werr
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_ok;
  logic rsv_ok;
  logic rsv_same;
  logic fwd_a;
  logic fwd_b;
  logic cnt_inc;
  logic cnt_dec;

  function automatic logic writable(input logic [AW-1:0] addr);
    return !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign wr_ok    = w && writable(RD);
  assign rsv_ok   = rsv && writable(rsv_rd);
  assign rsv_same = rsv_ok && (rsv_rd == RD);
  assign fwd_a    = wr_ok && (RD == RS1);
  assign fwd_b    = wr_ok && (RD == RS2);

  // A write to a busy register only lowers the count if no new owner reserves it this cycle.
  assign cnt_inc = rsv_ok && !busy[rsv_rd];
  assign cnt_dec = wr_ok && busy[RD] && !rsv_same;

  always_comb begin
    A = regs[RS1];
    if (!writable(RS1)) A = '0;
    if (fwd_a)          A = C;
  end

  always_comb begin
    B = regs[RS2];
    if (!writable(RS2)) B = '0;
    if (fwd_b)          B = C;
  end

  assign a_busy = busy[RS1] && !fwd_a;
  assign b_busy = busy[RS2] && !fwd_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[RD] <= C;
    end
  end

  // Reserve is applied after release so a same-register reservation keeps the bit set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[RD]     <= 1'b0;
      if (rsv_ok) busy[rsv_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
      werr     <= 1'b0;
    end else begin
      busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
      if (wr_ok && !busy[RD] && !rsv_same) werr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: checks regfile_sb in two configurations (32x32 with zero register,
// 8x16 without) against a behavioural scoreboard model, directed steps then random traffic.
module tb_regfile_sb;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int          depth[2] = '{32, 8};
  int          zr[2]    = '{1, 0};
  logic [31:0] dmask[2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

  logic [4:0]  in_rs1[2];
  logic [4:0]  in_rs2[2];
  logic [4:0]  in_rd[2];
  logic [4:0]  in_rsv_rd[2];
  logic [31:0] in_c[2];
  logic        in_w[2];
  logic        in_rsv[2];

  logic [31:0] m_regs[2][32];
  bit          m_busy[2][32];
  bit          m_werr[2];

  logic [31:0] a0, b0;
  logic [15:0] a1, b1;
  logic        ab0, bb0, ab1, bb1, werr0, werr1;
  logic [5:0]  cnt0;
  logic [3:0]  cnt1;
  logic [31:0] saved;

  regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
    .clock(clock), .reset(reset),
    .RS1(in_rs1[0]), .RS2(in_rs2[0]), .A(a0), .B(b0), .a_busy(ab0), .b_busy(bb0),
    .w(in_w[0]), .RD(in_rd[0]), .C(in_c[0]),
    .rsv(in_rsv[0]), .rsv_rd(in_rsv_rd[0]), .busy_cnt(cnt0), .werr(werr0)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut1 (
    .clock(clock), .reset(reset),
    .RS1(in_rs1[1][2:0]), .RS2(in_rs2[1][2:0]), .A(a1), .B(b1), .a_busy(ab1), .b_busy(bb1),
    .w(in_w[1]), .RD(in_rd[1][2:0]), .C(in_c[1][15:0]),
    .rsv(in_rsv[1]), .rsv_rd(in_rsv_rd[1][2:0]), .busy_cnt(cnt1), .werr(werr1)
  );

  function automatic bit writable(int k, logic [4:0] addr);
    return !(zr[k] == 1 && addr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(int k, logic [4:0] addr);
    if (in_w[k] && writable(k, in_rd[k]) && in_rd[k] == addr) return in_c[k] & dmask[k];
    if (!writable(k, addr)) return '0;
    return m_regs[k][addr];
  endfunction

  function automatic bit exp_busy(int k, logic [4:0] addr);
    return m_busy[k][addr] && !(in_w[k] && writable(k, in_rd[k]) && in_rd[k] == addr);
  endfunction

  function automatic int exp_cnt(int k);
    int n = 0;
    for (int i = 0; i < depth[k]; i++) n += int'(m_busy[k][i]);
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_output(int k);
    if (k == 0) begin
      check("dut0_A", a0, exp_read(0, in_rs1[0]));
      check("dut0_B", b0, exp_read(0, in_rs2[0]));
      check("dut0_a_busy", 32'(ab0), 32'(exp_busy(0, in_rs1[0])));
      check("dut0_b_busy", 32'(bb0), 32'(exp_busy(0, in_rs2[0])));
      check("dut0_busy_cnt", 32'(cnt0), 32'(exp_cnt(0)));
      check("dut0_werr", 32'(werr0), 32'(m_werr[0]));
    end else begin
      check("dut1_A", 32'(a1), exp_read(1, in_rs1[1]));
      check("dut1_B", 32'(b1), exp_read(1, in_rs2[1]));
      check("dut1_a_busy", 32'(ab1), 32'(exp_busy(1, in_rs1[1])));
      check("dut1_b_busy", 32'(bb1), 32'(exp_busy(1, in_rs2[1])));
      check("dut1_busy_cnt", 32'(cnt1), 32'(exp_cnt(1)));
      check("dut1_werr", 32'(werr1), 32'(m_werr[1]));
    end
  endtask

  task automatic clear_model(int k);
    for (int i = 0; i < 32; i++) begin
      m_regs[k][i] = '0;
      m_busy[k][i] = 1'b0;
    end
    m_werr[k] = 1'b0;
  endtask

  task automatic update_model(int k);
    bit wr;
    bit rv;
    if (!reset) begin
      clear_model(k);
      return;
    end
    wr = in_w[k] && writable(k, in_rd[k]);
    rv = in_rsv[k] && writable(k, in_rsv_rd[k]);
    if (wr) begin
      if (!m_busy[k][in_rd[k]] && !(rv && in_rsv_rd[k] == in_rd[k])) m_werr[k] = 1'b1;
      m_regs[k][in_rd[k]] = in_c[k] & dmask[k];
      m_busy[k][in_rd[k]] = 1'b0;
    end
    if (rv) m_busy[k][in_rsv_rd[k]] = 1'b1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      in_rs1[k] = '0; in_rs2[k] = '0; in_rd[k] = '0; in_rsv_rd[k] = '0;
      in_c[k] = '0; in_w[k] = 1'b0; in_rsv[k] = 1'b0;
    end
  endtask

  task automatic apply_random();
    for (int k = 0; k < 2; k++) begin
      in_rs1[k]    = 5'($urandom_range(depth[k] - 1));
      in_rs2[k]    = 5'($urandom_range(depth[k] - 1));
      in_rd[k]     = 5'($urandom_range(depth[k] - 1));
      in_rsv_rd[k] = 5'($urandom_range(depth[k] - 1));
      in_c[k]      = $urandom;
      in_w[k]      = 1'($urandom_range(1));
      in_rsv[k]    = 1'($urandom_range(1));
    end
  endtask

  // Checks combinational outputs before the edge, then advances the model past it.
  task automatic cycle();
    #1;
    check_output(0);
    check_output(1);
    @(posedge clock);
    update_model(0);
    update_model(1);
    @(negedge clock);
  endtask

  task automatic reset_mid();
    apply_random();
    for (int k = 0; k < 2; k++) begin
      in_w[k] = 1'b1;
      in_rsv[k] = 1'b1;
    end
    #3 reset = 1'b0;
    #1;
    clear_model(0);
    clear_model(1);
    check_output(0);
    check_output(1);
    check("rst_async_cnt0", 32'(cnt0), 32'd0);
    check("rst_async_werr0", 32'(werr0), 32'd0);
    @(posedge clock);
    #1;
    check_output(0);
    check_output(1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    idle();
    clear_model(0);
    clear_model(1);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      in_rs1[0] = 5'(i);
      in_rs2[0] = 5'(31 - i);
      in_rs1[1] = 5'(i % 8);
      in_rs2[1] = 5'(7 - (i % 8));
      #1;
      check_output(0);
      check_output(1);
    end
    check("rst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // reserve 5, observe busy, then forwarded write releases it
    idle(); in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd5; cycle();
    idle(); in_rs1[0] = 5'd5;
    #1 check("busy5_a_busy", 32'(ab0), 32'd1);
    check("busy5_cnt", 32'(cnt0), 32'd1);
    cycle();
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd5; in_c[0] = 32'hDEAD_BEEF; in_rs1[0] = 5'd5; in_rs2[0] = 5'd5;
    #1 check("fwd_A", a0, 32'hDEAD_BEEF);
    check("fwd_B", b0, 32'hDEAD_BEEF);
    check("fwd_a_busy", 32'(ab0), 32'd0);
    cycle();
    idle(); in_rs1[0] = 5'd5;
    #1 check("rel5_cnt", 32'(cnt0), 32'd0);
    check("rel5_werr", 32'(werr0), 32'd0);
    check("rel5_A", a0, 32'hDEAD_BEEF);
    cycle();

    // register 0 ignores writes and reservations
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd0; in_c[0] = 32'hFFFF_FFFF;
    in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd0;
    #1 check("zero_fwd_A", a0, 32'd0);
    cycle();
    idle();
    #1 check("zero_A", a0, 32'd0);
    check("zero_cnt", 32'(cnt0), 32'd0);
    check("zero_werr", 32'(werr0), 32'd0);
    cycle();

    // write and re-reserve the same register, then write 7 while reserving 3
    idle(); in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd7; cycle();
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd7; in_c[0] = $urandom;
    in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd7; cycle();
    idle(); in_rs1[0] = 5'd7;
    #1 check("rersv7_busy", 32'(ab0), 32'd1);
    check("rersv7_cnt", 32'(cnt0), 32'd1);
    in_w[0] = 1'b1; in_rd[0] = 5'd7; in_c[0] = $urandom;
    in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd3;
    cycle();
    idle(); in_rs1[0] = 5'd3; in_rs2[0] = 5'd7;
    #1 check("swap_a_busy3", 32'(ab0), 32'd1);
    check("swap_b_busy7", 32'(bb0), 32'd0);
    check("swap_cnt", 32'(cnt0), 32'd1);
    check("swap_werr", 32'(werr0), 32'd0);
    cycle();

    // unreserved write sets sticky werr
    saved = $urandom;
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd9; in_c[0] = saved; cycle();
    idle(); in_rs1[0] = 5'd9;
    #1 check("werr_set", 32'(werr0), 32'd1);
    check("werr_data", a0, saved);
    cycle();
    idle(); in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'd4; cycle();
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd4; in_c[0] = $urandom; cycle();
    idle(); in_w[0] = 1'b1; in_rd[0] = 5'd3; in_c[0] = $urandom; cycle();
    idle();
    #1 check("werr_sticky", 32'(werr0), 32'd1);
    cycle();

    // fill the scoreboards, then reset asynchronously mid-cycle
    for (int i = 1; i < 32; i++) begin
      idle();
      in_rsv[0] = 1'b1; in_rsv_rd[0] = 5'(i);
      if (i <= 8) begin
        in_rsv[1] = 1'b1; in_rsv_rd[1] = 5'(i - 1);
      end
      cycle();
    end
    idle();
    #1 check("full_cnt0", 32'(cnt0), 32'd31);
    check("full_cnt1", 32'(cnt1), 32'd8);
    cycle();
    reset_mid();

    for (int n = 0; n < 400; n++) begin
      apply_random();
      cycle();
      if (n == 200) reset_mid();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
